// File: rtl/ram_1w2r_pkg.sv
// Shared definitions for the ram_1w2r dual-read RAM: size defaults, the
// sweep FSM encoding and the read-output source selector.
package ram_1w2r_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEEPTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Where a read port takes its data from after the sampling edge.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_FWD  = 2'd2
    } rsel_t;

    // A read sampled during a sweep returns zero; a read that collides with
    // an accepted write returns the new data; otherwise the bank answers.
    function automatic rsel_t read_sel(input logic busy, input logic fwd_hit);
        rsel_t sel;
        sel = SEL_MEM;
        if (busy)
            sel = SEL_ZERO;
        else if (fwd_hit)
            sel = SEL_FWD;
        return sel;
    endfunction

endpackage

// File: rtl/ram_1r1w.sv
// One-write / one-read memory bank with a registered read port.
// The read register clears on reset; the array itself is not reset.
module ram_1r1w
    import ram_1w2r_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEEPTH = DEF_DEEPTH
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              i_we,
    input  logic [DEEPTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [DEEPTH-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port: commit the word at the rising edge.
    // NOTE: the array has no reset branch so it maps onto RAM macros; zeroing
    // is done by the owner's sweep, never by a reset fan-out to every word.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Registered read: returns the pre-write contents on an address collision.
    // NOTE: non-blocking assignments keep the read and write of the same edge
    // order-independent; blocking here would make the result depend on
    // process scheduling.
    always_ff @(posedge clk) begin
        if (!clrn)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_1w2r.sv
// One-write / two-read RAM built from two replicated ram_1r1w banks, with
// write-first forwarding per read port and an optional bulk-clear sweep.
// Build option: define RAM_1W2R_FLUSH_EN to enable flush, busy and the
// post-reset clear; without it busy is 0, flush is ignored and reset only
// clears the read outputs.
module ram_1w2r
    import ram_1w2r_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEEPTH = DEF_DEEPTH
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              W_en,
    input  logic [DEEPTH-1:0] W_addr,
    input  logic [WIDTH-1:0]  W_data,
    input  logic              R_en_A,
    input  logic [DEEPTH-1:0] R_addr_A,
    output logic [WIDTH-1:0]  R_data_A,
    input  logic              R_en_B,
    input  logic [DEEPTH-1:0] R_addr_B,
    output logic [WIDTH-1:0]  R_data_B,
    input  logic              flush,
    output logic              busy
);

    logic              w_busy;
    logic              w_sweep_we;
    logic [DEEPTH-1:0] w_sweep_addr;
    logic              w_wr_acc;
    logic              w_bank_we;
    logic [DEEPTH-1:0] w_bank_waddr;
    logic [WIDTH-1:0]  w_bank_wdata;
    logic [WIDTH-1:0]  w_bank_a;
    logic [WIDTH-1:0]  w_bank_b;
    rsel_t             r_sel_a;
    rsel_t             r_sel_b;
    logic [WIDTH-1:0]  r_fwd_a;
    logic [WIDTH-1:0]  r_fwd_b;

`ifdef RAM_1W2R_FLUSH_EN
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DEEPTH-1:0] r_cnt;
    logic [DEEPTH-1:0] w_cnt_nxt;

    // Sweep state and address; reset (even mid-sweep) restarts from word 0.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: one word zeroed per cycle; the counter wraps to 0 as the
    // last word is written, so leaving CLEAR costs no extra cycle.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush)
                    w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_sweep_we = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (&r_cnt)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_busy       = (r_state == ST_CLEAR);
    assign w_sweep_addr = r_cnt;
`else
    logic w_unused_flush;

    assign w_unused_flush = flush;
    assign w_busy         = 1'b0;
    assign w_sweep_we     = 1'b0;
    assign w_sweep_addr   = '0;
`endif

    assign busy         = w_busy;
    assign w_wr_acc     = W_en & ~w_busy & clrn;
    assign w_bank_we    = w_sweep_we | w_wr_acc;
    assign w_bank_waddr = w_sweep_we ? w_sweep_addr : W_addr;
    assign w_bank_wdata = w_sweep_we ? '0 : W_data;

    ram_1r1w #(.WIDTH(WIDTH), .DEEPTH(DEEPTH)) u_bank_a (
        .clk     (clk),
        .clrn    (clrn),
        .i_we    (w_bank_we),
        .i_waddr (w_bank_waddr),
        .i_wdata (w_bank_wdata),
        .i_re    (R_en_A),
        .i_raddr (R_addr_A),
        .o_rdata (w_bank_a)
    );

    ram_1r1w #(.WIDTH(WIDTH), .DEEPTH(DEEPTH)) u_bank_b (
        .clk     (clk),
        .clrn    (clrn),
        .i_we    (w_bank_we),
        .i_waddr (w_bank_waddr),
        .i_wdata (w_bank_wdata),
        .i_re    (R_en_B),
        .i_raddr (R_addr_B),
        .o_rdata (w_bank_b)
    );

    // Per-port source select and forwarded word, updated only on a read so
    // the output holds while the port is idle.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_sel_a <= SEL_ZERO;
            r_sel_b <= SEL_ZERO;
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else begin
            if (R_en_A) begin
                r_sel_a <= read_sel(w_busy, w_wr_acc && (W_addr == R_addr_A));
                r_fwd_a <= W_data;
            end
            if (R_en_B) begin
                r_sel_b <= read_sel(w_busy, w_wr_acc && (W_addr == R_addr_B));
                r_fwd_b <= W_data;
            end
        end
    end

    // Output mux: bank data unless the sampled read was forwarded or zeroed.
    always_comb begin
        R_data_A = w_bank_a;
        R_data_B = w_bank_b;
        case (r_sel_a)
            SEL_ZERO: R_data_A = '0;
            SEL_FWD:  R_data_A = r_fwd_a;
            default:  ;
        endcase
        case (r_sel_b)
            SEL_ZERO: R_data_B = '0;
            SEL_FWD:  R_data_B = r_fwd_b;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_ram_1w2r.sv
// Self-checking bench for ram_1w2r: fill, vector table, randomized traffic
// against a word-array reference model, and flush/reset corner sequences.
// Build option: RAM_1W2R_FLUSH_EN selects the flush-enabled expectations.
module tb_ram_1w2r;

    localparam int WIDTH  = 8;
    localparam int DEEPTH = 8;
    localparam int NWORDS = 1 << DEEPTH;
`ifdef RAM_1W2R_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clrn;
    logic              W_en;
    logic [DEEPTH-1:0] W_addr;
    logic [WIDTH-1:0]  W_data;
    logic              R_en_A;
    logic [DEEPTH-1:0] R_addr_A;
    logic [WIDTH-1:0]  R_data_A;
    logic              R_en_B;
    logic [DEEPTH-1:0] R_addr_B;
    logic [WIDTH-1:0]  R_data_B;
    logic              flush;
    logic              busy;

    always #5 clk = ~clk;

    ram_1w2r #(.WIDTH(WIDTH), .DEEPTH(DEEPTH)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .W_en     (W_en),
        .W_addr   (W_addr),
        .W_data   (W_data),
        .R_en_A   (R_en_A),
        .R_addr_A (R_addr_A),
        .R_data_A (R_data_A),
        .R_en_B   (R_en_B),
        .R_addr_B (R_addr_B),
        .R_data_B (R_data_B),
        .flush    (flush),
        .busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain word array plus a count of words left to clear.
    logic [7:0] m_mem [NWORDS];
    bit         m_known [NWORDS];
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    bit         a_known = 1'b0;
    bit         b_known = 1'b0;
    int         clear_left = 0;

    typedef struct {
        bit         we;
        logic [7:0] wa;
        logic [7:0] wd;
        bit         ra_en;
        logic [7:0] ra;
        bit         rb_en;
        logic [7:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one clock cycle, advance the model, and compare after the edge.
    task automatic cycle(input bit rst, input bit we, input logic [7:0] wa, input logic [7:0] wd,
                         input bit ra_en, input logic [7:0] ra,
                         input bit rb_en, input logic [7:0] rb, input bit fl);
        bit busy_now;
        bit acc;
        clrn = ~rst; W_en = we; W_addr = wa; W_data = wd;
        R_en_A = ra_en; R_addr_A = ra; R_en_B = rb_en; R_addr_B = rb; flush = fl;
        if (rst) begin
            m_a = '0; m_b = '0; a_known = 1'b1; b_known = 1'b1;
            clear_left = FLUSH_EN ? NWORDS : 0;
            if (!FLUSH_EN)
                for (int i = 0; i < NWORDS; i++) m_known[i] = 1'b0;
        end else begin
            busy_now = (clear_left > 0);
            acc      = we && !busy_now;
            if (ra_en) begin
                if (busy_now)              begin m_a = '0; a_known = 1'b1; end
                else if (acc && wa == ra)  begin m_a = wd; a_known = 1'b1; end
                else                       begin m_a = m_mem[ra]; a_known = m_known[ra]; end
            end
            if (rb_en) begin
                if (busy_now)              begin m_b = '0; b_known = 1'b1; end
                else if (acc && wa == rb)  begin m_b = wd; b_known = 1'b1; end
                else                       begin m_b = m_mem[rb]; b_known = m_known[rb]; end
            end
            if (acc) begin
                m_mem[wa]   = wd;
                m_known[wa] = 1'b1;
            end
            if (busy_now) begin
                m_mem[NWORDS - clear_left]   = '0;
                m_known[NWORDS - clear_left] = 1'b1;
                clear_left--;
            end else if (fl && FLUSH_EN) begin
                clear_left = NWORDS;
            end
        end
        @(posedge clk);
        #1;
        check("busy", busy, clear_left > 0);
        if (a_known) check("rdata_a", R_data_A, m_a);
        if (b_known) check("rdata_b", R_data_B, m_b);
    endtask

    task automatic idle();
        cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cycle(0, 1, a, d, 0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] b);
        cycle(0, 0, 8'h00, 8'h00, 1, a, 1, b, 0);
    endtask

    // Count edges until busy drops, bounded so a stuck busy cannot hang.
    task automatic count_sweep(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            idle();
            n++;
        end
        check(name, n, NWORDS);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clrn = 1'b0; W_en = 1'b0; W_addr = '0; W_data = '0;
        R_en_A = 1'b0; R_addr_A = '0; R_en_B = 1'b0; R_addr_B = '0; flush = 1'b0;
        for (int i = 0; i < NWORDS; i++) m_known[i] = 1'b0;

        // Reset state
        cycle(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        check("reset_a", R_data_A, 8'h00);
        check("reset_b", R_data_B, 8'h00);
        check("reset_busy", busy, FLUSH_EN);

`ifdef RAM_1W2R_FLUSH_EN
        // Post-reset sweep length, then the memory reads back zero
        count_sweep("reset_sweep_len");
        rd(8'h00, 8'h7F);
        check("swept_00", R_data_A, 8'h00);
        check("swept_7f", R_data_B, 8'h00);
        rd(8'hFF, 8'hFF);
        check("swept_ff", R_data_A, 8'h00);
`endif

        // Fill every word with addr ^ 0x5A
        for (int i = 0; i < NWORDS; i++) wr(i[7:0], i[7:0] ^ 8'h5A);

        // Directed vector table (expected values relative to the fill)
        vecs[0] = '{0, 8'h00, 8'h00, 1, 8'h03, 1, 8'h04, 8'h59, 8'h5E};
        vecs[1] = '{1, 8'h10, 8'hA5, 0, 8'h00, 0, 8'h00, 8'h59, 8'h5E};
        vecs[2] = '{0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h10, 8'hA5, 8'hA5};
        vecs[3] = '{1, 8'h20, 8'h3C, 1, 8'h20, 1, 8'h21, 8'h3C, 8'h7B};
        vecs[4] = '{1, 8'h20, 8'hC3, 1, 8'h20, 1, 8'h20, 8'hC3, 8'hC3};
        vecs[5] = '{0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'hC3, 8'hC3};
        vecs[6] = '{0, 8'h00, 8'h00, 1, 8'hFF, 1, 8'h00, 8'hA5, 8'h5A};
        vecs[7] = '{1, 8'h00, 8'h11, 0, 8'h00, 1, 8'h00, 8'hA5, 8'h11};
        vecs[8] = '{0, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 8'h11, 8'h11};
        vecs[9] = '{1, 8'hFF, 8'hEE, 1, 8'hFE, 1, 8'hFF, 8'hA4, 8'hEE};
        for (int i = 0; i < 10; i++) begin
            cycle(0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra_en, vecs[i].ra,
                  vecs[i].rb_en, vecs[i].rb, 0);
            check($sformatf("vec%0d_a", i), R_data_A, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), R_data_B, vecs[i].exp_b);
        end

        // Randomized traffic on a narrow address window to force collisions
        for (int i = 0; i < 400; i++) begin
            cycle(0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 2) != 0, 8'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0, 8'($urandom_range(0, 15)),
                  $urandom_range(0, 99) == 0);
        end
        while (busy === 1'b1 && clear_left > 0) idle();

`ifdef RAM_1W2R_FLUSH_EN
        // Flush: a write during the sweep is dropped, a second flush is ignored
        wr(8'h05, 8'h99);
        wr(8'h10, 8'h42);
        cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1);
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            cycle(0, n == 10, 8'h05, 8'hFF, n == 20, 8'h10, 0, 8'h00, n == 100);
            if (n == 20) check("read_during_sweep", R_data_A, 8'h00);
            n++;
        end
        check("flush_sweep_len", n, NWORDS);
        rd(8'h05, 8'h10);
        check("dropped_write_05", R_data_A, 8'h00);
        check("flushed_10", R_data_B, 8'h00);

        // Reset mid-sweep restarts a full sweep
        wr(8'hC0, 8'h11);
        cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 50; i++) idle();
        cycle(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        count_sweep("restart_sweep_len");
        rd(8'hC0, 8'hC0);
        check("reset_cleared_c0", R_data_A, 8'h00);
`else
        // Flush has no effect when the sweep is not built
        wr(8'h01, 8'h77);
        cycle(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1);
        check("flush_ignored_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        rd(8'h01, 8'h01);
        check("flush_ignored_a", R_data_A, 8'h77);
        check("flush_ignored_b", R_data_B, 8'h77);
`endif

        // Final reset clears both read outputs
        rd(8'h10, 8'h11);
        cycle(1, 0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h11, 0);
        check("final_reset_a", R_data_A, 8'h00);
        check("final_reset_b", R_data_B, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
